// File: rtl/wb_port_arbiter_if.sv
// Writeback port bus between the pipeline (master) and the write-port arbiter (slave).
interface wb_port_arbiter_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            ld_we;
  logic [4:0]      ld_rd;
  logic [XLEN-1:0] ld_data;
  logic            alu_we;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic [4:0]      rs1_q;
  logic [4:0]      rs2_q;
  logic            rf_we;
  logic [4:0]      rf_a;
  logic [XLEN-1:0] rf_wd;
  logic            stall;
  logic [1:0]      pend_hit;
  logic [CW-1:0]   fifo_cnt;

  // Pipeline side: issues writeback requests and hazard queries.
  modport master (
    output ld_we, ld_rd, ld_data, alu_we, alu_rd, alu_data, rs1_q, rs2_q,
    input  rf_we, rf_a, rf_wd, stall, pend_hit, fifo_cnt
  );

  // Arbiter side: owns the register-file write port.
  modport slave (
    input  ld_we, ld_rd, ld_data, alu_we, alu_rd, alu_data, rs1_q, rs2_q,
    output rf_we, rf_a, rf_wd, stall, pend_hit, fifo_cnt
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter: loads always win, losing ALU writes
// wait in a small in-order FIFO, stall is raised when that FIFO is full.
module wb_port_arbiter #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  wb_port_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // FIFO state
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_cnt;
  logic [DEPTH-1:0] r_valid;
  logic [4:0]      r_rd   [DEPTH];
  logic [XLEN-1:0] r_data [DEPTH];

  // Registered write port
  logic            r_rf_we;
  logic [4:0]      r_rf_a;
  logic [XLEN-1:0] r_rf_wd;

  logic            w_empty;
  logic            w_full;
  logic            w_ld_valid;
  logic            w_alu_acc;
  logic            w_alu_valid;
  logic            w_deq;
  logic            w_bypass;
  logic            w_enq;
  logic            w_we_next;
  logic [4:0]      w_a_next;
  logic [XLEN-1:0] w_wd_next;
  logic [1:0]      w_pend;

  assign w_empty     = (r_cnt == '0);
  assign w_full      = (r_cnt == FULL_CNT);
  // rd=0 requests are dropped, but an ALU request is still consumed when not stalled.
  assign w_ld_valid  = bus.ld_we && (bus.ld_rd != 5'd0);
  assign w_alu_acc   = bus.alu_we && !w_full;
  assign w_alu_valid = w_alu_acc && (bus.alu_rd != 5'd0);
  // The FIFO head drains only when no load owns the port.
  assign w_deq       = !w_ld_valid && !w_empty;
  // An ALU write may skip the FIFO only when nothing older is waiting.
  assign w_bypass    = !w_ld_valid && w_empty && w_alu_valid;
  assign w_enq       = w_alu_valid && !w_bypass;

  // Pick the port winner for the next cycle; address/data hold when idle.
  always_comb begin
    w_we_next = 1'b0;
    w_a_next  = r_rf_a;
    w_wd_next = r_rf_wd;
    if (w_ld_valid) begin
      w_we_next = 1'b1;
      w_a_next  = bus.ld_rd;
      w_wd_next = bus.ld_data;
    end else if (w_deq) begin
      w_we_next = 1'b1;
      w_a_next  = r_rd[r_head];
      w_wd_next = r_data[r_head];
    end else if (w_bypass) begin
      w_we_next = 1'b1;
      w_a_next  = bus.alu_rd;
      w_wd_next = bus.alu_data;
    end
  end

  // Write-port output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rf_we <= 1'b0;
      r_rf_a  <= 5'd0;
      r_rf_wd <= '0;
    end else begin
      r_rf_we <= w_we_next;
      r_rf_a  <= w_a_next;
      r_rf_wd <= w_wd_next;
    end
  end

  // FIFO pointers and occupancy; simultaneous enqueue and dequeue leave the count unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_deq) r_head <= r_head + 1'b1;
      if (w_enq) r_tail <= r_tail + 1'b1;
      case ({w_enq, w_deq})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Entry valid flags and destination tags, which the hazard lookup needs cleared on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) r_rd[i] <= 5'd0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        // Enqueue and dequeue never target the same slot: both only happen when 0<cnt<DEPTH.
        if (w_enq && (r_tail == PW'(i))) begin
          r_valid[i] <= 1'b1;
          r_rd[i]    <= bus.alu_rd;
        end else if (w_deq && (r_head == PW'(i))) begin
          r_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Payload storage; stale data is harmless because validity is tracked separately.
  always_ff @(posedge clk) begin
    if (w_enq) r_data[r_tail] <= bus.alu_data;
  end

  // Hazard lookup: a query hits any buffered write or the write currently on the port.
  always_comb begin
    w_pend = 2'b00;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (r_rd[i] == bus.rs1_q)) w_pend[0] = 1'b1;
      if (r_valid[i] && (r_rd[i] == bus.rs2_q)) w_pend[1] = 1'b1;
    end
    if (r_rf_we && (r_rf_a == bus.rs1_q)) w_pend[0] = 1'b1;
    if (r_rf_we && (r_rf_a == bus.rs2_q)) w_pend[1] = 1'b1;
    if (bus.rs1_q == 5'd0) w_pend[0] = 1'b0;
    if (bus.rs2_q == 5'd0) w_pend[1] = 1'b0;
  end

  assign bus.rf_we    = r_rf_we;
  assign bus.rf_a     = r_rf_a;
  assign bus.rf_wd    = r_rf_wd;
  assign bus.stall    = w_full;
  assign bus.pend_hit = w_pend;
  assign bus.fifo_cnt = r_cnt;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_wb_port_arbiter;
  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  logic clk;
  logic reset;

  wb_port_arbiter_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  wb_port_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ent_t;

  // Reference model: pending ALU writes in arrival order, plus the expected port value.
  ent_t            mq[$];
  logic            exp_we;
  logic [4:0]      exp_a;
  logic [XLEN-1:0] exp_wd;

  int total;
  int bad;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_pend(input logic [4:0] q);
    if (q == 5'd0) return 1'b0;
    if (exp_we && exp_a == q) return 1'b1;
    foreach (mq[i]) if (mq[i].rd == q) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_all();
    logic [1:0] pend;
    pend = {model_pend(bus.rs2_q), model_pend(bus.rs1_q)};
    check_val("rf_we",    64'(bus.rf_we),    64'(exp_we));
    check_val("rf_a",     64'(bus.rf_a),     64'(exp_a));
    check_val("rf_wd",    64'(bus.rf_wd),    64'(exp_wd));
    check_val("fifo_cnt", 64'(bus.fifo_cnt), 64'(mq.size()));
    check_val("stall",    64'(bus.stall),    64'(mq.size() == DEPTH));
    check_val("pend_hit", 64'(bus.pend_hit), 64'(pend));
  endtask

  task automatic drive(input bit lw, input logic [4:0] lr, input logic [XLEN-1:0] ld,
                       input bit aw, input logic [4:0] ar, input logic [XLEN-1:0] ad,
                       input logic [4:0] q1, input logic [4:0] q2);
    bus.ld_we = lw; bus.ld_rd = lr; bus.ld_data = ld;
    bus.alu_we = aw; bus.alu_rd = ar; bus.alu_data = ad;
    bus.rs1_q = q1; bus.rs2_q = q2;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, bus.rs1_q, bus.rs2_q);
  endtask

  // One clock: update the model from the current inputs, step the DUT, compare.
  task automatic cycle(output bit acc);
    bit   full, ld_ok, alu_ok;
    ent_t e;
    full   = (mq.size() == DEPTH);
    acc    = bus.alu_we && !full;
    ld_ok  = bus.ld_we && (bus.ld_rd != 5'd0);
    alu_ok = acc && (bus.alu_rd != 5'd0);
    e.rd   = bus.alu_rd;
    e.data = bus.alu_data;
    if (ld_ok) begin
      exp_we = 1'b1; exp_a = bus.ld_rd; exp_wd = bus.ld_data;
      if (alu_ok) mq.push_back(e);
    end else if (mq.size() != 0) begin
      ent_t h;
      h = mq.pop_front();
      exp_we = 1'b1; exp_a = h.rd; exp_wd = h.data;
      if (alu_ok) mq.push_back(e);
    end else if (alu_ok) begin
      exp_we = 1'b1; exp_a = e.rd; exp_wd = e.data;
    end else begin
      exp_we = 1'b0;
    end
    @(posedge clk);
    #1;
    if (exp_we) $display("t=%0t write x%0d=%h cnt=%0d", $time, exp_a, exp_wd, mq.size());
    else        $display("t=%0t no write cnt=%0d", $time, mq.size());
    check_all();
  endtask

  // Keep re-presenting the current ALU request until the arbiter takes it.
  task automatic hold_alu(input string tag);
    bit acc;
    acc = 1'b0;
    for (int n = 0; n < 8 && !acc; n++) cycle(acc);
    check_val(tag, 64'(acc), 64'd1);
  endtask

  task automatic drain(input int n);
    bit acc;
    idle();
    for (int i = 0; i < n; i++) cycle(acc);
  endtask

  initial begin
    bit acc;
    bit held;
    total = 0; bad = 0;
    mq.delete();
    exp_we = 1'b0; exp_a = 5'd0; exp_wd = '0;
    reset = 1'b1;
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 5'd0, 5'd0);
    #1;
    check_all();
    @(posedge clk); #1;
    reset = 1'b0;

    // Lone ALU write bypasses the empty FIFO.
    drive(1'b0, 5'd0, '0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
    cycle(acc);
    drain(1);

    // Load and ALU together: load first, ALU one cycle later; x4 pending meanwhile.
    drive(1'b1, 5'd3, 32'h11111111, 1'b1, 5'd4, 32'h22222222, 5'd4, 5'd3);
    cycle(acc);
    drain(2);

    // Three load+ALU cycles fill the FIFO; the third ALU request has to wait.
    drive(1'b1, 5'd1, 32'hA0000001, 1'b1, 5'd2, 32'hB0000002, 5'd2, 5'd6);
    cycle(acc);
    drive(1'b1, 5'd3, 32'hA0000003, 1'b1, 5'd4, 32'hB0000004, 5'd2, 5'd6);
    cycle(acc);
    drive(1'b1, 5'd5, 32'hA0000005, 1'b1, 5'd6, 32'hB0000006, 5'd4, 5'd6);
    cycle(acc);
    check_val("third_alu_held", 64'(acc), 64'd0);
    drive(1'b0, 5'd0, '0, 1'b1, 5'd6, 32'hB0000006, 5'd4, 5'd6);
    hold_alu("held_alu_accept");
    drain(3);

    // rd=0 on both requesters: nothing written, nothing buffered.
    drive(1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0, 32'h87654321, 5'd0, 5'd0);
    cycle(acc);
    drain(1);

    // Concurrent dequeue and enqueue at cnt=1.
    drive(1'b1, 5'd7, 32'h77777777, 1'b1, 5'd8, 32'h88888888, 5'd8, 5'd9);
    cycle(acc);
    drive(1'b0, 5'd0, '0, 1'b1, 5'd9, 32'h99999999, 5'd8, 5'd9);
    cycle(acc);
    drain(2);

    // Asynchronous reset with two entries buffered.
    drive(1'b1, 5'd10, 32'h0A0A0A0A, 1'b1, 5'd11, 32'h0B0B0B0B, 5'd11, 5'd12);
    cycle(acc);
    drive(1'b1, 5'd13, 32'h0D0D0D0D, 1'b1, 5'd12, 32'h0C0C0C0C, 5'd11, 5'd12);
    cycle(acc);
    idle();
    #2;
    reset = 1'b1;
    mq.delete();
    exp_we = 1'b0; exp_a = 5'd0; exp_wd = '0;
    #1;
    $display("t=%0t reset asserted mid-operation", $time);
    check_all();
    @(posedge clk); #1;
    reset = 1'b0;
    drain(3);

    // Random traffic; a refused ALU request is held stable until accepted.
    held = 1'b0;
    for (int n = 0; n < 400; n++) begin
      logic [4:0]      ar;
      logic [XLEN-1:0] ad;
      bit              aw;
      if (held) begin
        aw = 1'b1; ar = bus.alu_rd; ad = bus.alu_data;
      end else begin
        aw = ($urandom_range(0, 9) < 6);
        ar = 5'($urandom_range(0, 7));
        ad = $urandom;
      end
      drive(($urandom_range(0, 9) < 4), 5'($urandom_range(0, 7)), $urandom,
            aw, ar, ad, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      cycle(acc);
      held = aw && !acc;
    end
    drain(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
